// File: rtl/fft4_pkg.sv
// Shared definitions for the fft4 streaming wrapper: default widths, latency
// and FSM state encodings.
package fft4_pkg;

    localparam int unsigned NB_INPUT_DEF    = 8;
    localparam int unsigned NB_OUTPUT_DEF   = 10;
    localparam int unsigned FFT_LATENCY_DEF = 4;
    localparam int unsigned N_POINTS        = 4;

    typedef enum logic {
        COL_FILL = 1'b0,
        COL_FULL = 1'b1
    } col_state_e;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/fft4_frame_buf.sv
// Two-frame result FIFO: whole frame written at once, one word read by bin index.
module fft4_frame_buf
    import fft4_pkg::*;
#(
    parameter int unsigned W = 20
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_x0_i,
    input  logic [W-1:0] wr_x1_i,
    input  logic [W-1:0] wr_x2_i,
    input  logic [W-1:0] wr_x3_i,
    input  logic         pop_i,
    input  logic [1:0]   rd_idx_i,
    output logic [W-1:0] rd_data_o,
    output logic [W-1:0] next_x0_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2][N_POINTS];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    always_comb begin
        count_d = count_q;
        unique case ({wr_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_i) begin
                mem_q[wr_ptr_q][0] <= wr_x0_i;
                mem_q[wr_ptr_q][1] <= wr_x1_i;
                mem_q[wr_ptr_q][2] <= wr_x2_i;
                mem_q[wr_ptr_q][3] <= wr_x3_i;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q][rd_idx_i];
    // Word 0 of the frame behind the head, used to chain frames without a bubble.
    assign next_x0_o = mem_q[~rd_ptr_q][0];
    assign count_o   = count_q;

endmodule

// File: rtl/fft4_frame_ctrl.sv
// Streaming sequencer around fft4: collects 4-sample frames, launches them under
// credit control, checks result timing and serialises results in bin order.
module fft4_frame_ctrl
    import fft4_pkg::*;
#(
    parameter int unsigned NB_INPUT    = NB_INPUT_DEF,
    parameter int unsigned NB_OUTPUT   = NB_OUTPUT_DEF,
    parameter int unsigned FFT_LATENCY = FFT_LATENCY_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [2*NB_INPUT-1:0]  i_sample,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [2*NB_INPUT-1:0]  o_fft_x0,
    output logic [2*NB_INPUT-1:0]  o_fft_x1,
    output logic [2*NB_INPUT-1:0]  o_fft_x2,
    output logic [2*NB_INPUT-1:0]  o_fft_x3,
    output logic                   o_fft_valid,
    output logic                   o_fft_enable,
    input  logic [2*NB_OUTPUT-1:0] i_fft_x0,
    input  logic [2*NB_OUTPUT-1:0] i_fft_x1,
    input  logic [2*NB_OUTPUT-1:0] i_fft_x2,
    input  logic [2*NB_OUTPUT-1:0] i_fft_x3,
    input  logic                   i_fft_valid,
    output logic [2*NB_OUTPUT-1:0] o_result,
    output logic [1:0]             o_index,
    output logic                   o_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_err
);

    localparam int unsigned SW = 2 * NB_INPUT;
    localparam int unsigned RW = 2 * NB_OUTPUT;

    col_state_e             col_q, col_d;
    logic [1:0]             slot_q, slot_d;
    logic [SW-1:0]          x_q [N_POINTS];
    logic [SW-1:0]          x_d [N_POINTS];
    logic                   ready_q, ready_d;
    logic                   fft_valid_q, fft_valid_d;
    logic                   enable_q;
    logic [1:0]             credit_q, credit_d;
    logic [FFT_LATENCY-1:0] tok_q;
    logic                   err_q, err_d;
    ser_state_e             ser_q, ser_d;
    logic [1:0]             idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [RW-1:0]          result_q, result_d;

    logic          launch_c;
    logic          tap_c;
    logic          buf_wr_c;
    logic          miss_c;
    logic          pop_c;
    logic [1:0]    count_c;
    logic [1:0]    rd_idx_c;
    logic [RW-1:0] rd_data_c;
    logic [RW-1:0] next_x0_c;

    // Collector: fill four slots, then launch once a credit is available.
    always_comb begin
        col_d       = col_q;
        slot_d      = slot_q;
        x_d         = x_q;
        ready_d     = 1'b0;
        fft_valid_d = 1'b0;
        launch_c    = 1'b0;
        unique case (col_q)
            COL_FILL: begin
                ready_d = 1'b1;
                if (i_valid && ready_q) begin
                    x_d[slot_q] = i_sample;
                    slot_d      = slot_q + 2'd1;
                    if (slot_q == 2'd3) begin
                        col_d   = COL_FULL;
                        ready_d = 1'b0;
                    end
                end
            end
            COL_FULL: begin
                if (credit_q != 2'd0) begin
                    launch_c    = 1'b1;
                    fft_valid_d = 1'b1;
                    ready_d     = 1'b1;
                    col_d       = COL_FILL;
                end
            end
            default: col_d = COL_FILL;
        endcase
    end

    // Expected-result token versus actual fft4 valid; mismatches are flagged.
    always_comb begin
        tap_c    = tok_q[FFT_LATENCY-1];
        buf_wr_c = tap_c & i_fft_valid;
        miss_c   = tap_c & ~i_fft_valid;
        err_d    = err_q | (tap_c ^ i_fft_valid);
        credit_d = credit_q + 2'(pop_c) + 2'(miss_c) - 2'(launch_c);
    end

    assign rd_idx_c = (ser_q == SER_SEND) ? idx_q + 2'd1 : 2'd0;

    // Serializer: walk bins 0..3 of the head frame, chaining into the next frame.
    always_comb begin
        ser_d    = ser_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        result_d = result_q;
        pop_c    = 1'b0;
        unique case (ser_q)
            SER_IDLE: begin
                if (count_c != 2'd0) begin
                    ser_d    = SER_SEND;
                    idx_d    = 2'd0;
                    valid_d  = 1'b1;
                    result_d = rd_data_c;
                end
            end
            SER_SEND: begin
                if (valid_q && i_ready) begin
                    if (idx_q == 2'd3) begin
                        pop_c = 1'b1;
                        idx_d = 2'd0;
                        if (count_c == 2'd2) begin
                            result_d = next_x0_c;
                        end else if (buf_wr_c) begin
                            result_d = i_fft_x0;
                        end else begin
                            ser_d   = SER_IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        result_d = rd_data_c;
                    end
                end
            end
            default: ser_d = SER_IDLE;
        endcase
        last_d = valid_d & (idx_d == 2'd3);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q       <= COL_FILL;
            slot_q      <= 2'd0;
            x_q         <= '{default: '0};
            ready_q     <= 1'b0;
            fft_valid_q <= 1'b0;
            enable_q    <= 1'b0;
            credit_q    <= 2'd2;
            tok_q       <= '0;
            err_q       <= 1'b0;
            ser_q       <= SER_IDLE;
            idx_q       <= 2'd0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            col_q       <= col_d;
            slot_q      <= slot_d;
            x_q         <= x_d;
            ready_q     <= ready_d;
            fft_valid_q <= fft_valid_d;
            enable_q    <= 1'b1;
            credit_q    <= credit_d;
            tok_q       <= (tok_q << 1) | FFT_LATENCY'(fft_valid_q);
            err_q       <= err_d;
            ser_q       <= ser_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            result_q    <= result_d;
        end
    end

    fft4_frame_buf #(
        .W (RW)
    ) u_buf (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .wr_i      (buf_wr_c),
        .wr_x0_i   (i_fft_x0),
        .wr_x1_i   (i_fft_x1),
        .wr_x2_i   (i_fft_x2),
        .wr_x3_i   (i_fft_x3),
        .pop_i     (pop_c),
        .rd_idx_i  (rd_idx_c),
        .rd_data_o (rd_data_c),
        .next_x0_o (next_x0_c),
        .count_o   (count_c)
    );

    assign o_ready      = ready_q;
    assign o_fft_x0     = x_q[0];
    assign o_fft_x1     = x_q[1];
    assign o_fft_x2     = x_q[2];
    assign o_fft_x3     = x_q[3];
    assign o_fft_valid  = fft_valid_q;
    assign o_fft_enable = enable_q;
    assign o_result     = result_q;
    assign o_index      = idx_q;
    assign o_last       = last_q;
    assign o_valid      = valid_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// Bench for fft4_frame_ctrl with a behavioural 4-point DFT standing in for fft4;
// expected results are queued at stimulus time and checked by a separate monitor.
module tb_fft4_frame_ctrl;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_sample;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_fft_x0, o_fft_x1, o_fft_x2, o_fft_x3;
    logic        o_fft_valid;
    logic        o_fft_enable;
    logic [19:0] i_fft_x0, i_fft_x1, i_fft_x2, i_fft_x3;
    logic        i_fft_valid;
    logic [19:0] o_result;
    logic [1:0]  o_index;
    logic        o_last;
    logic        o_valid;
    logic        i_ready;
    logic        o_err;

    int n_vec    = 0;
    int n_miss   = 0;
    int n_launch = 0;
    int drop_req = 0;
    int drop_ack = 0;
    logic force_valid = 1'b0;

    logic [22:0] exp_q [$];
    logic [79:0] st_x [L];
    logic        st_v [L];

    always #5 clk = ~clk;

    fft4_frame_ctrl dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_sample     (i_sample),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_fft_x0     (o_fft_x0),
        .o_fft_x1     (o_fft_x1),
        .o_fft_x2     (o_fft_x2),
        .o_fft_x3     (o_fft_x3),
        .o_fft_valid  (o_fft_valid),
        .o_fft_enable (o_fft_enable),
        .i_fft_x0     (i_fft_x0),
        .i_fft_x1     (i_fft_x1),
        .i_fft_x2     (i_fft_x2),
        .i_fft_x3     (i_fft_x3),
        .i_fft_valid  (i_fft_valid),
        .o_result     (o_result),
        .o_index      (o_index),
        .o_last       (o_last),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_err        (o_err)
    );

    function automatic logic [79:0] fft_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [15:0] d);
        int ar, ai, br, bi, cr, ci, dr, di;
        int r0, i0, r1, i1, r2, i2, r3, i3;
        ar = int'($signed(a[15:8])); ai = int'($signed(a[7:0]));
        br = int'($signed(b[15:8])); bi = int'($signed(b[7:0]));
        cr = int'($signed(c[15:8])); ci = int'($signed(c[7:0]));
        dr = int'($signed(d[15:8])); di = int'($signed(d[7:0]));
        r0 = ar + br + cr + dr;  i0 = ai + bi + ci + di;
        r1 = ar + bi - cr - di;  i1 = ai - br - ci + dr;
        r2 = ar - br + cr - dr;  i2 = ai - bi + ci - di;
        r3 = ar - bi - cr + di;  i3 = ai + br - ci - dr;
        return {10'(r3), 10'(i3), 10'(r2), 10'(i2), 10'(r1), 10'(i1), 10'(r0), 10'(i0)};
    endfunction

    // fft4 stand-in: fixed latency pipe, optionally dropping one launched frame.
    always @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < L; i++) st_v[i] <= 1'b0;
        end else begin
            st_v[0] <= o_fft_valid && (drop_ack == drop_req);
            st_x[0] <= fft_ref(o_fft_x0, o_fft_x1, o_fft_x2, o_fft_x3);
            for (int i = 1; i < L; i++) begin
                st_v[i] <= st_v[i-1];
                st_x[i] <= st_x[i-1];
            end
            if (o_fft_valid && (drop_ack != drop_req)) drop_ack <= drop_ack + 1;
        end
    end

    assign i_fft_valid = st_v[L-1] | force_valid;
    assign i_fft_x0    = st_x[L-1][19:0];
    assign i_fft_x1    = st_x[L-1][39:20];
    assign i_fft_x2    = st_x[L-1][59:40];
    assign i_fft_x3    = st_x[L-1][79:60];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output is compared against the head of the queue.
    initial begin
        logic [22:0] e;
        forever begin
            @(negedge clk);
            if (!i_rst && o_valid && i_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_out: got idx %0d data 0x%0h, expected nothing",
                             o_index, o_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_index, o_last, o_result} !== e) begin
                        n_miss++;
                        $display("FAIL result: got idx %0d last %0b data 0x%05h, expected idx %0d last %0b data 0x%05h",
                                 o_index, o_last, o_result, e[22:21], e[20], e[19:0]);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_fft_valid === 1'b1) n_launch++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [19:0] e0, input logic [19:0] e1,
                              input logic [19:0] e2, input logic [19:0] e3);
        exp_q.push_back({2'd0, 1'b0, e0});
        exp_q.push_back({2'd1, 1'b0, e1});
        exp_q.push_back({2'd2, 1'b0, e2});
        exp_q.push_back({2'd3, 1'b1, e3});
    endtask

    task automatic send(input logic [15:0] s);
        logic acc;
        int   t;
        t        = 0;
        i_sample = s;
        i_valid  = 1'b1;
        forever begin
            acc = o_ready;
            @(posedge clk);
            #1;
            if (acc === 1'b1) break;
            t++;
            if (t > 200) begin
                check("send_accept", 32'd0, 32'd1);
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic send4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic wait_launch(input string name, output logic [15:0] x0, output logic [15:0] x1);
        int t;
        t = 0;
        while (o_fft_valid !== 1'b1 && t < 20) begin
            cycles(1);
            t++;
        end
        check({name, "_launch"}, 32'(o_fft_valid), 32'd1);
        x0 = o_fft_x0;
        x1 = o_fft_x1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            cycles(1);
            t++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cycles(2);
        i_rst = 1'b0;
        cycles(1);
    endtask

    initial begin
        logic [15:0] x0, x1;
        int base, ok;

        // Reset with input valid held high
        i_rst = 1'b1; i_valid = 1'b1; i_sample = 16'h1234; i_ready = 1'b1;
        cycles(3);
        check("rst_ready",  32'(o_ready),      32'd0);
        check("rst_fvalid", 32'(o_fft_valid),  32'd0);
        check("rst_enable", 32'(o_fft_enable), 32'd0);
        check("rst_valid",  32'(o_valid),      32'd0);
        check("rst_err",    32'(o_err),        32'd0);
        check("rst_outs",   32'({o_result, o_index, o_last}), 32'd0);
        check("rst_x0",     32'(o_fft_x0),     32'd0);
        i_rst = 1'b0; i_valid = 1'b0;
        cycles(1);
        check("rel_ready",  32'(o_ready),      32'd1);
        check("rel_enable", 32'(o_fft_enable), 32'd1);

        // Single impulse frame
        push_frame(20'h1FC00, 20'h1FC00, 20'h1FC00, 20'h1FC00);
        send4(16'h7F00, 16'h0000, 16'h0000, 16'h0000);
        wait_launch("single", x0, x1);
        check("single_x0", 32'(x0), 32'h7F00);
        cycles(1);
        check("single_pulse", 32'(o_fft_valid), 32'd0);
        wait_drain("single", 50);
        check("single_err", 32'(o_err), 32'd0);

        // Backpressure: two frames in credit, third stalls in FULL
        i_ready = 1'b0;
        base = n_launch;
        push_frame(20'h02800, 20'hFF802, 20'hFF800, 20'hFFBFE);
        push_frame(20'h00001, 20'h00001, 20'h00001, 20'h00001);
        push_frame(20'h01004, 20'h00000, 20'h00000, 20'h00000);
        push_frame(20'h01400, 20'h003FB, 20'hFEC00, 20'h00005);
        fork
            begin
                send4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
                send4(16'h0001, 16'h0000, 16'h0000, 16'h0000);
                send4(16'h0101, 16'h0101, 16'h0101, 16'h0101);
                send4(16'h0000, 16'h0500, 16'h0000, 16'h0000);
            end
            begin
                cycles(40);
                check("bp_ready",   32'(o_ready),         32'd0);
                check("bp_launch",  32'(n_launch - base), 32'd2);
                check("bp_hold",    32'({o_valid, o_index}), 32'h4);
                check("bp_data",    32'(o_result),        32'h02800);
                i_ready = 1'b1;
                ok = 0;
                for (int i = 0; i < 8; i++) begin
                    if (o_valid === 1'b1) ok++;
                    cycles(1);
                end
                check("bp_nobubble", 32'(ok), 32'd8);
            end
        join
        wait_drain("bp", 300);
        check("bp_launch_all", 32'(n_launch - base), 32'd4);
        check("bp_err", 32'(o_err), 32'd0);

        // Unexpected fft valid with nothing in flight
        force_valid = 1'b1;
        cycles(1);
        force_valid = 1'b0;
        check("unexp_err", 32'(o_err), 32'd1);
        ok = 0;
        for (int i = 0; i < 3; i++) begin
            if (o_valid === 1'b0) ok++;
            cycles(1);
        end
        check("unexp_novalid", 32'(ok), 32'd3);
        i_ready = 1'b0;
        base = n_launch;
        push_frame(20'h1FC00, 20'h1FC00, 20'h1FC00, 20'h1FC00);
        push_frame(20'h00001, 20'h00001, 20'h00001, 20'h00001);
        send4(16'h7F00, 16'h0000, 16'h0000, 16'h0000);
        send4(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        cycles(20);
        check("unexp_credit", 32'(n_launch - base), 32'd2);
        i_ready = 1'b1;
        wait_drain("unexp", 100);
        check("err_sticky", 32'(o_err), 32'd1);

        // Missing result: dropped frame yields nothing, its credit comes back
        do_reset();
        check("rst2_err",   32'(o_err),   32'd0);
        check("rst2_ready", 32'(o_ready), 32'd1);
        drop_req = drop_req + 1;
        send4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        cycles(15);
        check("miss_err",     32'(o_err),   32'd1);
        check("miss_novalid", 32'(o_valid), 32'd0);
        i_ready = 1'b0;
        base = n_launch;
        push_frame(20'h00001, 20'h00001, 20'h00001, 20'h00001);
        push_frame(20'h01004, 20'h00000, 20'h00000, 20'h00000);
        send4(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        send4(16'h0101, 16'h0101, 16'h0101, 16'h0101);
        cycles(25);
        check("miss_credit", 32'(n_launch - base), 32'd2);
        i_ready = 1'b1;
        wait_drain("miss", 100);

        // Reset with partial frame, one frame in flight and one buffered
        i_ready = 1'b0;
        send4(16'h7F00, 16'h0000, 16'h0000, 16'h0000);
        send4(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        send(16'h0101);
        send(16'h0101);
        do_reset();
        check("mid_valid", 32'(o_valid), 32'd0);
        check("mid_err",   32'(o_err),   32'd0);
        check("mid_ready", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        push_frame(20'h01400, 20'h003FB, 20'hFEC00, 20'h00005);
        send4(16'h0000, 16'h0500, 16'h0000, 16'h0000);
        wait_launch("mid", x0, x1);
        check("mid_x0", 32'(x0), 32'h0000);
        check("mid_x1", 32'(x1), 32'h0500);
        wait_drain("mid", 50);
        cycles(3);
        check("end_err",   32'(o_err),   32'd0);
        check("end_valid", 32'(o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
